// File: rtl/temporal_pkg.sv
// Shared definitions for the race-logic temporal gates: default timing
// parameters, slot-width derivation and a population count helper.
package temporal_pkg;

    localparam int DEFAULT_GAMMA_CYCLE_WIDTH = 16;
    localparam int DEFAULT_PULSE_WIDTH       = 8;
    localparam int MAX_INPUTS                = 32;

    function automatic int tw_of(input int gamma_cycle_width);
        return $clog2(gamma_cycle_width);
    endfunction

    function automatic int popcount(input logic [MAX_INPUTS-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < MAX_INPUTS; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/temporal_rank_n_if.sv
// Signal bundle for the k-of-N temporal rank gate.
// No valid/ready pair: inputs are sampled every aclk edge, and done is a
// one-cycle strobe qualifying y_time/y_none, which then hold until the next done.
interface temporal_rank_n_if
    import temporal_pkg::*;
#(
    parameter int N_IN              = 4,
    parameter int GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH
);
    localparam int KW = $clog2(N_IN + 1);
    localparam int TW = tw_of(GAMMA_CYCLE_WIDTH);

    logic [KW-1:0]   k;
    logic [N_IN-1:0] a;
    logic            y;
    logic            done;
    logic [TW-1:0]   y_time;
    logic            y_none;

    modport master (output k, output a, input y, input done, input y_time, input y_none);
    modport slave  (input k, input a, output y, output done, output y_time, output y_none);

endinterface

// File: rtl/gamma_counter.sv
// Free-running gamma-cycle slot counter; wrap marks the last slot of a cycle.
module gamma_counter
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
    parameter int TW                = tw_of(GAMMA_CYCLE_WIDTH)
) (
    input  logic          aclk,
    input  logic          grst_n,
    output logic [TW-1:0] gcnt,
    output logic          wrap
);
    localparam logic [TW-1:0] LAST_SLOT = TW'(GAMMA_CYCLE_WIDTH - 1);

    logic [TW-1:0] gcnt_q;
    logic [TW-1:0] gcnt_d;

    always_comb begin
        gcnt_d = (gcnt_q == LAST_SLOT) ? '0 : gcnt_q + TW'(1);
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign gcnt = gcnt_q;
    assign wrap = (gcnt_q == LAST_SLOT);

endmodule

// File: rtl/temporal_rank_n.sv
// Pulse-width-coded k-of-N temporal rank gate: fires one pulse when the k-th
// channel arrives in a gamma cycle and reports the arrival slot at the wrap.
module temporal_rank_n
    import temporal_pkg::*;
#(
    parameter int N_IN              = 4,
    parameter int GAMMA_CYCLE_WIDTH = DEFAULT_GAMMA_CYCLE_WIDTH,
    parameter int PULSE_WIDTH       = DEFAULT_PULSE_WIDTH
) (
    input  logic               aclk,
    input  logic               grst_n,
    temporal_rank_n_if.slave   bus
);
    localparam int TW  = tw_of(GAMMA_CYCLE_WIDTH);
    localparam int KW  = $clog2(N_IN + 1);
    localparam int PCW = (PULSE_WIDTH > 1) ? $clog2(PULSE_WIDTH) : 1;

    logic [TW-1:0] gcnt;
    logic          wrap;
    logic          slot0;

    gamma_counter #(
        .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
        .TW                (TW)
    ) u_gamma_counter (
        .aclk   (aclk),
        .grst_n (grst_n),
        .gcnt   (gcnt),
        .wrap   (wrap)
    );

    logic [N_IN-1:0]       lat_q,    lat_d;
    logic [KW-1:0]         count_q,  count_d;
    logic                  fired_q,  fired_d;
    logic [KW-1:0]         k_q,      k_d;
    logic [TW-1:0]         time_q,   time_d;
    logic                  y_q,      y_d;
    logic [PCW-1:0]        pcnt_q,   pcnt_d;
    logic                  done_q,   done_d;
    logic [TW-1:0]         y_time_q, y_time_d;
    logic                  y_none_q, y_none_d;

    logic [N_IN-1:0]       new_arr;
    logic [MAX_INPUTS-1:0] new_zext;
    logic [KW-1:0]         count_sum;
    logic [KW-1:0]         k_eff;
    logic                  fire;

    assign slot0 = (gcnt == '0);

    // In slot 0 the freshly presented k already governs, so a t=0 arrival can fire.
    always_comb begin
        k_eff    = slot0 ? bus.k : k_q;
        new_arr  = bus.a & ~lat_q;
        new_zext = '0;
        new_zext[N_IN-1:0] = new_arr;
        count_sum = count_q + KW'(popcount(new_zext));
        fire      = !fired_q && (k_eff != '0) && (count_sum >= k_eff);
    end

    always_comb begin
        lat_d    = lat_q | bus.a;
        count_d  = count_sum;
        fired_d  = fired_q | fire;
        k_d      = k_eff;
        time_d   = fire ? gcnt : time_q;
        y_d      = y_q;
        pcnt_d   = pcnt_q;
        done_d   = wrap;
        y_time_d = y_time_q;
        y_none_d = y_none_q;

        if (fire) begin
            y_d    = 1'b1;
            pcnt_d = PCW'(PULSE_WIDTH - 1);
        end else if (y_q) begin
            if (pcnt_q == '0) begin
                y_d = 1'b0;
            end else begin
                pcnt_d = pcnt_q - PCW'(1);
            end
        end

        // Wrap publishes this cycle's result (including a last-slot fire) and
        // truncates any pulse still running.
        if (wrap) begin
            y_time_d = time_d;
            y_none_d = !(fired_q | fire);
            lat_d    = '0;
            count_d  = '0;
            fired_d  = 1'b0;
            y_d      = 1'b0;
            pcnt_d   = '0;
        end
    end

    always_ff @(posedge aclk or negedge grst_n) begin
        if (!grst_n) begin
            lat_q    <= '0;
            count_q  <= '0;
            fired_q  <= 1'b0;
            k_q      <= '0;
            time_q   <= '0;
            y_q      <= 1'b0;
            pcnt_q   <= '0;
            done_q   <= 1'b0;
            y_time_q <= '0;
            y_none_q <= 1'b1;
        end else begin
            lat_q    <= lat_d;
            count_q  <= count_d;
            fired_q  <= fired_d;
            k_q      <= k_d;
            time_q   <= time_d;
            y_q      <= y_d;
            pcnt_q   <= pcnt_d;
            done_q   <= done_d;
            y_time_q <= y_time_d;
            y_none_q <= y_none_d;
        end
    end

    assign bus.y      = y_q;
    assign bus.done   = done_q;
    assign bus.y_time = y_time_q;
    assign bus.y_none = y_none_q;

endmodule

// File: tb/tb_temporal_rank_n.sv
// Bench for temporal_rank_n: directed test-plan cycles plus random cycles
// checked against an order-statistic model of each gamma cycle.
module tb_temporal_rank_n;
    import temporal_pkg::*;

    localparam int N  = 4;
    localparam int G  = 16;
    localparam int PW = 8;
    localparam int KW = $clog2(N + 1);

    logic aclk = 1'b0;
    logic grst_n;

    always #5 aclk = ~aclk;

    temporal_rank_n_if #(.N_IN(N), .GAMMA_CYCLE_WIDTH(G)) bus ();

    temporal_rank_n #(
        .N_IN              (N),
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk   (aclk),
        .grst_n (grst_n),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [N-1:0] wave [G];
    logic         first_cycle;
    int           exp_time;
    logic         exp_none;
    int           last_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_wave();
        for (int s = 0; s < G; s++) wave[s] = '0;
    endtask

    task automatic rise(input int ch, input int slot, input int len);
        for (int s = slot; s < slot + len && s < G; s++) wave[s][ch] = 1'b1;
    endtask

    // k-th smallest first-arrival slot of the cycle, or -1 for "infinity".
    function automatic int model_fire(input int kv);
        int arr[$];
        for (int i = 0; i < N; i++) begin
            for (int s = 0; s < G; s++) begin
                if (wave[s][i]) begin
                    arr.push_back(s);
                    break;
                end
            end
        end
        arr.sort();
        if (kv >= 1 && kv <= arr.size()) return arr[kv-1];
        return -1;
    endfunction

    // Entered at the negedge inside slot 0; leaves at the negedge inside slot stop_at.
    task automatic run_cycle(input int kv, input int stop_at, input int k_mid);
        int   t;
        logic exp_y;
        t = model_fire(kv);
        for (int s = 0; s < stop_at; s++) begin
            exp_y = (t >= 0) && (s > t) && (s <= t + PW);
            chk($sformatf("y@%0d", s), 32'(bus.y), 32'(exp_y));
            chk($sformatf("done@%0d", s), 32'(bus.done), 32'(s == 0 && !first_cycle));
            chk($sformatf("y_time@%0d", s), 32'(bus.y_time), 32'(exp_time));
            chk($sformatf("y_none@%0d", s), 32'(bus.y_none), 32'(exp_none));
            bus.a = wave[s];
            bus.k = (s == 0) ? KW'(kv) : KW'(k_mid);
            @(negedge aclk);
        end
        if (stop_at == G) begin
            first_cycle = 1'b0;
            if (t >= 0) begin
                last_t   = t;
                exp_none = 1'b0;
            end else begin
                exp_none = 1'b1;
            end
            exp_time = last_t;
        end
    endtask

    task automatic reset_model();
        first_cycle = 1'b1;
        exp_time    = 0;
        exp_none    = 1'b1;
        last_t      = 0;
    endtask

    task automatic random_cycle();
        int st;
        int len;
        clear_wave();
        for (int ch = 0; ch < N; ch++) begin
            if ($urandom_range(3) != 0) begin
                st  = $urandom_range(G - 1);
                len = $urandom_range(5, 1);
                rise(ch, st, len);
                if ($urandom_range(1) == 1) rise(ch, st + len + 1 + $urandom_range(3), 2);
            end
        end
        run_cycle($urandom_range(5), G, $urandom_range(4));
    endtask

    initial begin
        grst_n = 1'b0;
        bus.a  = '0;
        bus.k  = '0;
        reset_model();
        repeat (3) @(negedge aclk);
        chk("reset_y", 32'(bus.y), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_y_time", 32'(bus.y_time), 32'd0);
        chk("reset_y_none", 32'(bus.y_none), 32'd1);
        grst_n = 1'b1;

        // k=N: max of four staggered arrivals
        clear_wave();
        rise(0, 2, 8); rise(1, 4, 8); rise(2, 5, 8); rise(3, 7, 8);
        run_cycle(4, G, 4);

        // k=1: min
        clear_wave();
        rise(2, 3, 8); rise(0, 6, 8); rise(1, 6, 8); rise(3, 6, 8);
        run_cycle(1, G, 1);

        // k=2: simultaneous arrivals, later arrivals and a re-rise do not re-fire
        clear_wave();
        rise(0, 2, 3); rise(1, 2, 3); rise(2, 5, 2); rise(3, 9, 2); rise(0, 12, 2);
        run_cycle(2, G, 2);

        // k=4 with only three arrivals
        clear_wave();
        rise(0, 1, 4); rise(1, 3, 4); rise(3, 8, 4);
        run_cycle(4, G, 4);

        // k=0 never fires
        clear_wave();
        rise(0, 1, 4); rise(1, 2, 4); rise(2, 3, 4); rise(3, 4, 4);
        run_cycle(0, G, 0);

        // k=3, third arrival at 12: truncated pulse; mid-cycle k=1 ignored
        clear_wave();
        rise(0, 1, 3); rise(1, 6, 3); rise(2, 12, 3);
        run_cycle(3, G, 1);

        // Arrivals at t=0 and a fire in the last slot
        clear_wave();
        rise(1, 0, 2); rise(3, 0, 2);
        run_cycle(2, G, 2);
        clear_wave();
        rise(1, 15, 1);
        run_cycle(1, G, 1);

        for (int r = 0; r < 24; r++) random_cycle();

        // Reset while the output pulse is high
        clear_wave();
        rise(2, 3, 8);
        run_cycle(1, 9, 1);
        chk("pre_reset_y", 32'(bus.y), 32'd1);
        grst_n = 1'b0;
        #1;
        chk("async_reset_y", 32'(bus.y), 32'd0);
        chk("async_reset_y_none", 32'(bus.y_none), 32'd1);
        chk("async_reset_y_time", 32'(bus.y_time), 32'd0);
        bus.a = '0;
        repeat (2) @(negedge aclk);
        grst_n = 1'b1;
        reset_model();

        clear_wave();
        rise(0, 4, 3); rise(1, 5, 3);
        run_cycle(2, G, 2);
        clear_wave();
        run_cycle(1, G, 1);
        clear_wave();
        run_cycle(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
